uart_tx_stage: RTL and testbench

//  Serial transmit stage that drains the 16-entry shift FIFO and drives an asynchronous UART line.
//  It takes words through the STB/ACK pop handshake: STB means "word valid", and a one-cycle ACK pops the word.
//  It serialises each word as start bit, WIDTH data bits LSB first, optional parity bit, then stop bit(s).
//  It sits between the FIFO FO_* outputs and the board TXD pin.

---
 rtl/uart_tx_stage.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stage.sv
// rtl/uart_tx_stage.sv - UART transmit stage draining a STB/ACK word source onto TXD.
// Frames are start, WIDTH data bits LSB first, optional parity, then STOP_BITS stop bits.
module uart_tx_stage #(
    parameter int WIDTH     = 8,
    parameter int BAUD_DIV  = 868,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             I_STB,
    input  logic [WIDTH-1:0] I_DAT,
    output logic             I_ACK,
    output logic             TXD,
    output logic             TX_BSY
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [15:0]   BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    generate
        if (BAUD_DIV < 4 || BAUD_DIV > 65535) begin : g_bad_baud
            $error("uart_tx_stage: BAUD_DIV out of range 4..65535");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_stage: STOP_BITS must be 1 or 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_par
            $error("uart_tx_stage: PARITY must be 0, 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic             txd_q, txd_d;
    logic             ack_q, ack_d;
    logic             bsy_q, bsy_d;
    logic             bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        ack_d   = 1'b0;
        bsy_d   = bsy_q;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                bsy_d = 1'b0;
                if (I_STB) begin
                    // Parity is taken from the word here, before shifting destroys it.
                    shift_d = I_DAT;
                    par_d   = (PARITY == 2) ? ~^I_DAT : ^I_DAT;
                    ack_d   = 1'b1;
                    txd_d   = 1'b0;
                    bsy_d   = 1'b1;
                    baud_d  = 16'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            txd_d   = par_q;
                            state_d = S_PAR;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        txd_d = shift_d[0];
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    bit_d   = '0;
                    txd_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bsy_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                bsy_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            ack_q   <= 1'b0;
            bsy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            ack_q   <= ack_d;
            bsy_q   <= bsy_d;
        end
    end

    assign I_ACK  = ack_q;
    assign TXD    = txd_q;
    assign TX_BSY = bsy_q;

endmodule

// File: tb/tb_uart_tx_stage.sv
// tb/tb_uart_tx_stage.sv - directed bench for uart_tx_stage at BAUD_DIV = 4.
// Instance 0 (8N1) is fed by a queue-based FIFO model; instances 1..3 (8E1, 8O1, 8N2) are driven directly.
module tb_uart_tx_stage;

    logic       clk;
    logic       rst;
    logic [3:1] stb_v;
    logic [7:0] dat_x;
    logic [3:0] ack_v;
    logic [3:0] txd_v;
    logic [3:0] bsy_v;
    logic       fifo_stb;
    logic [7:0] fifo_dat;
    logic [7:0] fq[$];

    int total;
    int bad;

    uart_tx_stage #(.WIDTH(8), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .CLK(clk), .RST(rst), .I_STB(fifo_stb), .I_DAT(fifo_dat),
        .I_ACK(ack_v[0]), .TXD(txd_v[0]), .TX_BSY(bsy_v[0]));
    uart_tx_stage #(.WIDTH(8), .BAUD_DIV(4), .PARITY(1), .STOP_BITS(1)) u_e1 (
        .CLK(clk), .RST(rst), .I_STB(stb_v[1]), .I_DAT(dat_x),
        .I_ACK(ack_v[1]), .TXD(txd_v[1]), .TX_BSY(bsy_v[1]));
    uart_tx_stage #(.WIDTH(8), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(1)) u_o1 (
        .CLK(clk), .RST(rst), .I_STB(stb_v[2]), .I_DAT(dat_x),
        .I_ACK(ack_v[2]), .TXD(txd_v[2]), .TX_BSY(bsy_v[2]));
    uart_tx_stage #(.WIDTH(8), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .CLK(clk), .RST(rst), .I_STB(stb_v[3]), .I_DAT(dat_x),
        .I_ACK(ack_v[3]), .TXD(txd_v[3]), .TX_BSY(bsy_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: registered STB/DAT, popped one edge after the ACK pulse.
    always @(posedge clk) begin
        if (ack_v[0] && fq.size() > 0) fq.delete(0);
        fifo_stb <= (fq.size() != 0);
        fifo_dat <= (fq.size() != 0) ? fq[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_wave(input logic [7:0] d, input int has_par,
                                             input logic pbit, input int stops);
        logic [63:0] w;
        logic [15:0] fb;
        int nb;
        w      = '1;
        fb     = '1;
        fb[0]  = 1'b0;
        fb[8:1] = d;
        if (has_par != 0) fb[9] = pbit;
        nb = 1 + 8 + has_par + stops;
        for (int i = 0; i < nb; i++)
            for (int c = 0; c < 4; c++) w[i*4+c] = fb[i];
        return w;
    endfunction

    task automatic run_frame(input string tag, input int sel, input logic [7:0] d, input bit push,
                             input int has_par, input logic pbit, input int stops);
        int flen;
        int bsy_cnt;
        int ack_cnt;
        bit found;
        logic [63:0] obs;
        logic [63:0] exp;
        flen = 4 * (2 + 8 + has_par + stops - 1);
        found = 0;
        obs = '1;
        bsy_cnt = 0;
        ack_cnt = 0;
        if (sel == 0) begin
            if (push) fq.push_back(d);
        end else begin
            dat_x = d;
            stb_v[sel] = 1'b1;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (txd_v[sel] == 1'b0) begin
                found = 1;
                break;
            end
        end
        chk({tag, "_start"}, 64'(found), 64'd1);
        if (!found) return;
        chk({tag, "_ack_at_start"}, 64'(ack_v[sel]), 64'd1);
        if (sel != 0) stb_v[sel] = 1'b0;
        obs[0] = txd_v[sel];
        if (bsy_v[sel]) bsy_cnt++;
        for (int k = 1; k < flen + 2; k++) begin
            @(negedge clk);
            obs[k] = txd_v[sel];
            if (bsy_v[sel]) bsy_cnt++;
            if (ack_v[sel]) ack_cnt++;
        end
        exp = exp_wave(d, has_par, pbit, stops);
        chk({tag, "_wave"}, obs, exp);
        chk({tag, "_bsy_len"}, 64'(bsy_cnt), 64'(flen));
        chk({tag, "_extra_ack"}, 64'(ack_cnt), 64'd0);
    endtask

    logic       tr_txd[0:159];
    logic       tr_ack[0:159];
    int         starts[3];
    logic [7:0] dec[3];

    initial begin
        int nf;
        int acks;
        int i;
        bit found;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        stb_v = '0;
        dat_x = 8'h00;

        // Reset held with a word waiting: outputs idle, no ACK.
        fq.push_back(8'h3C);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_idle", {61'd0, txd_v[0], ack_v[0], bsy_v[0]}, 64'b100);
        end
        rst = 1'b0;
        run_frame("post_rst_3c", 0, 8'h3C, 1'b0, 0, 1'b0, 1);

        run_frame("n1_a5", 0, 8'hA5, 1'b1, 0, 1'b0, 1);
        run_frame("n1_00", 0, 8'h00, 1'b1, 0, 1'b0, 1);
        run_frame("e1_07", 1, 8'h07, 1'b1, 1, 1'b1, 1);
        run_frame("o1_07", 2, 8'h07, 1'b1, 1, 1'b0, 1);
        run_frame("e1_03", 1, 8'h03, 1'b1, 1, 1'b0, 1);
        run_frame("n2_ff", 3, 8'hFF, 1'b1, 0, 1'b0, 2);

        // Three queued words sent back-to-back with a single idle cycle between frames.
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        fq.push_back(8'h33);
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            tr_txd[k] = txd_v[0];
            tr_ack[k] = ack_v[0];
        end
        acks = 0;
        for (int k = 0; k < 160; k++) if (tr_ack[k]) acks++;
        chk("b2b_ack_cnt", 64'(acks), 64'd3);
        nf = 0;
        i = 1;
        while (i < 120 && nf < 3) begin
            if (tr_txd[i] == 1'b0 && tr_txd[i-1] == 1'b1) begin
                starts[nf] = i;
                dec[nf] = '0;
                for (int b = 0; b < 8; b++) dec[nf][b] = tr_txd[i + 4*(b+1) + 2];
                nf++;
                i += 40;
            end else begin
                i++;
            end
        end
        chk("b2b_frames", 64'(nf), 64'd3);
        if (nf == 3) begin
            chk("b2b_dat0", 64'(dec[0]), 64'h11);
            chk("b2b_dat1", 64'(dec[1]), 64'h22);
            chk("b2b_dat2", 64'(dec[2]), 64'h33);
            chk("b2b_gap01", 64'(starts[1] - starts[0]), 64'd41);
            chk("b2b_gap12", 64'(starts[2] - starts[1]), 64'd41);
        end
        chk("b2b_fifo_empty", 64'(fifo_stb), 64'd0);

        // Reset during data bit 3 of 0x5A; the following queued word must still go out intact.
        fq.push_back(8'h5A);
        fq.push_back(8'hC3);
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (txd_v[0] == 1'b0) begin
                found = 1;
                break;
            end
        end
        chk("mid_rst_start", 64'(found), 64'd1);
        for (int c = 0; c < 17; c++) @(negedge clk);
        chk("mid_rst_bit3", {62'd0, txd_v[0], bsy_v[0]}, 64'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out", {61'd0, txd_v[0], ack_v[0], bsy_v[0]}, 64'b100);
        rst = 1'b0;
        run_frame("after_rst_c3", 0, 8'hC3, 1'b0, 0, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
